dual_port_ram_arbiter: RTL

//  Shares one synchronous dual-port RAM (1 write port, 1 read port, 1-cycle registered read)

---
 rtl/dual_port_ram_arbiter_if.sv | 36 +++
 rtl/dual_port_ram_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/dual_port_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the dual-port RAM arbiter.
// master = requesters plus RAM environment, slave = the arbiter itself.
interface dual_port_ram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    wr_req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_gnt;
    logic [NREQ-1:0]    rd_req;
    logic [NREQ*AW-1:0] rd_addr;
    logic [NREQ-1:0]    rd_gnt;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic               init_done;
    logic               ram_write_en;
    logic [AW-1:0]      ram_write_address;
    logic [DW-1:0]      ram_data_in;
    logic               ram_read_en;
    logic [AW-1:0]      ram_read_address;
    logic [DW-1:0]      ram_data_out;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
        input  ram_write_en, ram_write_address, ram_data_in, ram_read_en, ram_read_address
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        output wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
        output ram_write_en, ram_write_address, ram_data_in, ram_read_en, ram_read_address
    );
endinterface

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin write/read arbiter in front of a 1W/1R RAM; grants combinational, read data 1 cycle after grant.
// Writes win same-address collisions (read retried next cycle). DPRAM_INIT_EN adds a post-reset zero-fill sweep.
module dual_port_ram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    dual_port_ram_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
`ifdef DPRAM_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    // Returns {found, index} of the first request at or after ptr, wrapping at NREQ.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k >= NREQ) ? PW'(int'(ptr) + k - NREQ) : PW'(int'(ptr) + k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    state_t          state, state_nxt;
    logic [AW-1:0]   init_addr;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NREQ-1:0] rd_valid_q;
    logic [PW:0]     wr_pick, rd_pick;
    logic [PW-1:0]   wr_idx, rd_idx;
    logic            wr_found, rd_found;
    logic            run, init_active, wr_go, rd_go, collide;
    logic [AW-1:0]   wr_addr_sel, rd_addr_sel;
    logic [DW-1:0]   wr_data_sel;

    assign wr_pick = rr_pick(bus.wr_req, wr_ptr);
    assign rd_pick = rr_pick(bus.rd_req, rd_ptr);
    assign wr_found = wr_pick[PW];
    assign wr_idx   = wr_pick[PW-1:0];
    assign rd_found = rd_pick[PW];
    assign rd_idx   = rd_pick[PW-1:0];

    assign wr_addr_sel = bus.wr_addr[int'(wr_idx)*AW +: AW];
    assign wr_data_sel = bus.wr_data[int'(wr_idx)*DW +: DW];
    assign rd_addr_sel = bus.rd_addr[int'(rd_idx)*AW +: AW];

    // Gating with reset_n makes every grant and RAM enable drop the instant reset asserts.
    assign run         = reset_n && (state == ST_RUN);
    assign init_active = reset_n && (state == ST_INIT);

    assign wr_go   = run && wr_found;
    assign collide = wr_go && rd_found && (rd_addr_sel == wr_addr_sel);
    assign rd_go   = run && rd_found && !collide;

    always_comb begin
        bus.wr_gnt = '0;
        bus.rd_gnt = '0;
        if (wr_go) bus.wr_gnt[wr_idx] = 1'b1;
        if (rd_go) bus.rd_gnt[rd_idx] = 1'b1;
    end

    assign bus.ram_write_en      = init_active || wr_go;
    assign bus.ram_write_address = init_active ? init_addr : wr_addr_sel;
    assign bus.ram_data_in       = init_active ? '0 : wr_data_sel;
    assign bus.ram_read_en       = rd_go;
    assign bus.ram_read_address  = rd_addr_sel;
    assign bus.rd_valid          = rd_valid_q;
    assign bus.rd_data           = bus.ram_data_out;

`ifdef DPRAM_INIT_EN
    assign bus.init_done = run;
`else
    assign bus.init_done = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_addr == {AW{1'b1}}) state_nxt = ST_RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST_STATE;
            init_addr  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= '0;
        end else begin
            state <= state_nxt;
            if (init_active) init_addr <= init_addr + 1'b1;
            if (wr_go) wr_ptr <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
            if (rd_go) rd_ptr <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            rd_valid_q <= bus.rd_gnt;
        end
    end
endmodule
